// File: rtl/timer_sched.sv
// Multiplexes NumChan 64-bit deadlines onto one mtime/mtimecmp timer.
// The block reads mtime, expires due channels and programs mtimecmp with the earliest armed deadline.
module timer_sched #(
    parameter int unsigned NumChan = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddressWidth = 32,
    parameter logic [AddressWidth-1:0] TimerBase = 32'h0003_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_req_i,
    input  logic                    cfg_we_i,
    input  logic [AddressWidth-1:0] cfg_addr_i,
    input  logic [DataWidth-1:0]    cfg_wdata_i,
    output logic                    cfg_rvalid_o,
    output logic [DataWidth-1:0]    cfg_rdata_o,
    output logic                    cfg_err_o,
    output logic                    timer_req_o,
    output logic [AddressWidth-1:0] timer_addr_o,
    output logic                    timer_we_o,
    output logic [3:0]              timer_be_o,
    output logic [DataWidth-1:0]    timer_wdata_o,
    input  logic                    timer_rvalid_i,
    input  logic [DataWidth-1:0]    timer_rdata_i,
    input  logic                    timer_intr_i,
    output logic                    irq_o
);
    localparam int unsigned IdxW = $clog2(NumChan);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChan - 1);
    localparam logic [AddressWidth-1:0] AddrMtimeLo = TimerBase;
    localparam logic [AddressWidth-1:0] AddrMtimeHi = TimerBase + AddressWidth'(4);
    localparam logic [AddressWidth-1:0] AddrCmpLo = TimerBase + AddressWidth'(8);
    localparam logic [AddressWidth-1:0] AddrCmpHi = TimerBase + AddressWidth'(12);

    typedef enum logic [3:0] {
        StIdle, StRdHi, StRdLo, StRdHi2, StExpire, StScan, StWrLoMax, StWrHi, StWrLo
    } state_e;

    state_e            state_q, state_d;
    logic [63:0]       dl_q [NumChan];
    logic [63:0]       dl_d [NumChan];
    logic [NumChan-1:0] armed_q, armed_d, pend_q, pend_d;
    logic              dirty_q, dirty_d, irq_q;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [63:0]       now_q, now_d, best_q, best_d;

    // Register decode: channels at 16*c, PEND at 0x100, everything else unmapped.
    logic [9:0]      reg_addr;
    logic [IdxW-1:0] cidx;
    logic            ch_hit, sel_lo, sel_hi, sel_ctrl, sel_pend, cfg_wr, exp_hit;
    logic            unused_addr;

    assign reg_addr    = cfg_addr_i[9:0];
    assign unused_addr = ^cfg_addr_i[AddressWidth-1:10];
    assign cidx        = reg_addr[IdxW+3:4];
    assign ch_hit      = (reg_addr[9:8] == 2'b00) && (32'(reg_addr[7:4]) < NumChan);
    assign sel_lo      = ch_hit && (reg_addr[3:0] == 4'h0);
    assign sel_hi      = ch_hit && (reg_addr[3:0] == 4'h4);
    assign sel_ctrl    = ch_hit && (reg_addr[3:0] == 4'h8);
    assign sel_pend    = (reg_addr == 10'h100);
    assign cfg_wr      = cfg_req_i && cfg_we_i;
    assign exp_hit     = (state_q == StExpire) && armed_q[idx_q] && (dl_q[idx_q] <= now_q);

    always_comb begin
        cfg_rvalid_o = cfg_req_i;
        cfg_rdata_o  = '0;
        cfg_err_o    = 1'b0;
        if (cfg_req_i) begin
            if (sel_lo) begin
                cfg_rdata_o = dl_q[cidx][31:0];
            end else if (sel_hi) begin
                cfg_rdata_o = dl_q[cidx][63:32];
            end else if (sel_ctrl) begin
                cfg_rdata_o = DataWidth'({pend_q[cidx], armed_q[cidx]});
            end else if (sel_pend) begin
                cfg_rdata_o = DataWidth'(pend_q);
            end else begin
                cfg_err_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        dl_d          = dl_q;
        armed_d       = armed_q;
        pend_d        = pend_q;
        dirty_d       = dirty_q;
        idx_d         = idx_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        now_d         = now_q;
        best_d        = best_q;
        timer_req_o   = 1'b0;
        timer_we_o    = 1'b0;
        timer_be_o    = 4'h0;
        timer_addr_o  = '0;
        timer_wdata_o = '0;

        // W1C first so a same-cycle expiry set overrides it.
        if (cfg_wr && sel_ctrl && cfg_wdata_i[1]) pend_d[cidx] = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (timer_intr_i && (|armed_q)) begin
                    state_d = StRdHi;
                end else if (dirty_q) begin
                    state_d = StScan;
                    dirty_d = 1'b0;
                    idx_d   = '0;
                    best_d  = '1;
                end
            end
            StRdHi, StRdLo, StRdHi2: begin
                timer_req_o  = 1'b1;
                timer_be_o   = 4'hF;
                timer_addr_o = (state_q == StRdLo) ? AddrMtimeLo : AddrMtimeHi;
                if (timer_rvalid_i) begin
                    if (state_q == StRdHi) begin
                        hi_d    = timer_rdata_i;
                        state_d = StRdLo;
                    end else if (state_q == StRdLo) begin
                        lo_d    = timer_rdata_i;
                        state_d = StRdHi2;
                    end else if (timer_rdata_i != hi_q) begin
                        state_d = StRdHi;
                    end else begin
                        now_d   = {hi_q, lo_q};
                        idx_d   = '0;
                        state_d = StExpire;
                    end
                end
            end
            StExpire: begin
                if (exp_hit) begin
                    pend_d[idx_q]  = 1'b1;
                    armed_d[idx_q] = 1'b0;
                end
                if (idx_q == LastIdx) begin
                    state_d = StScan;
                    dirty_d = 1'b0;
                    idx_d   = '0;
                    best_d  = '1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StScan: begin
                // Strict compare keeps the lower index on ties.
                if (armed_q[idx_q] && (dl_q[idx_q] < best_q)) best_d = dl_q[idx_q];
                if (idx_q == LastIdx) state_d = StWrLoMax;
                else idx_d = idx_q + 1'b1;
            end
            StWrLoMax, StWrHi, StWrLo: begin
                timer_req_o = 1'b1;
                timer_we_o  = 1'b1;
                timer_be_o  = 4'hF;
                if (state_q == StWrLoMax) begin
                    timer_addr_o  = AddrCmpLo;
                    timer_wdata_o = '1;
                    if (timer_rvalid_i) state_d = StWrHi;
                end else if (state_q == StWrHi) begin
                    timer_addr_o  = AddrCmpHi;
                    timer_wdata_o = best_q[63:32];
                    if (timer_rvalid_i) state_d = StWrLo;
                end else begin
                    timer_addr_o  = AddrCmpLo;
                    timer_wdata_o = best_q[31:0];
                    if (timer_rvalid_i) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Cfg writes land last so they win over expiry and re-mark the schedule dirty.
        if (cfg_wr && sel_lo) begin
            dl_d[cidx][31:0] = cfg_wdata_i;
            if (armed_q[cidx]) dirty_d = 1'b1;
        end
        if (cfg_wr && sel_hi) begin
            dl_d[cidx][63:32] = cfg_wdata_i;
            if (armed_q[cidx]) dirty_d = 1'b1;
        end
        if (cfg_wr && sel_ctrl) begin
            armed_d[cidx] = cfg_wdata_i[0];
            if ((cfg_wdata_i[0] != armed_q[cidx]) || (exp_hit && (idx_q == cidx))) dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            dl_q    <= '{default: '0};
            armed_q <= '0;
            pend_q  <= '0;
            dirty_q <= 1'b0;
            irq_q   <= 1'b0;
            idx_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            now_q   <= '0;
            best_q  <= '0;
        end else begin
            state_q <= state_d;
            dl_q    <= dl_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            dirty_q <= dirty_d;
            irq_q   <= |pend_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            now_q   <= now_d;
            best_q  <= best_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: a behavioural mtime/mtimecmp slave plus directed and randomized
// deadline scenarios checked against an arithmetic model of the schedule.
module tb_timer_sched;
    localparam int unsigned NumChan = 4;
    localparam logic [31:0] Base = 32'h0003_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cfg_req = 1'b0, cfg_we = 1'b0;
    logic [31:0] cfg_addr = '0, cfg_wdata = '0;
    logic        cfg_rvalid, cfg_err;
    logic [31:0] cfg_rdata;
    logic        timer_req, timer_we, timer_rvalid, timer_intr, irq;
    logic [31:0] timer_addr, timer_wdata, timer_rdata;
    logic [3:0]  timer_be;

    timer_sched #(.NumChan(NumChan), .DataWidth(32), .AddressWidth(32), .TimerBase(Base)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .timer_req_o(timer_req), .timer_addr_o(timer_addr), .timer_we_o(timer_we),
        .timer_be_o(timer_be), .timer_wdata_o(timer_wdata), .timer_rvalid_i(timer_rvalid),
        .timer_rdata_i(timer_rdata), .timer_intr_i(timer_intr), .irq_o(irq)
    );

    // Timer slave model
    logic [63:0] mtime = '0, mtimecmp = '1, load_val = '0;
    bit          tick_en = 0, load_mtime = 0, force_intr = 0, bump_arm = 0, bump_done = 0;
    int          stall_hi_n = 0, stall_cnt = 0, stall_seen = 0, hi_reads = 0, stab_err = 0;
    logic [3:0]  wr_off_q[$];
    logic [31:0] wr_dat_q[$];
    logic [31:0] toff, prev_addr = '0, prev_wdata = '0;
    logic        stalling, prev_stall = 1'b0, prev_we = 1'b0;

    assign toff         = timer_addr - Base;
    assign stalling     = timer_req && timer_we && (toff == 32'd12) && (stall_cnt < stall_hi_n);
    assign timer_rvalid = !stalling;
    assign timer_intr   = (mtime >= mtimecmp) || force_intr;

    always_comb begin
        case (toff)
            32'd0:   timer_rdata = mtime[31:0];
            32'd4:   timer_rdata = mtime[63:32];
            32'd8:   timer_rdata = mtimecmp[31:0];
            32'd12:  timer_rdata = mtimecmp[63:32];
            default: timer_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (load_mtime) mtime <= load_val;
        else if (tick_en) mtime <= mtime + 64'd1;
        if (timer_req && stalling) begin
            stall_cnt  <= stall_cnt + 1;
            stall_seen <= stall_seen + 1;
        end else if (timer_req) begin
            stall_cnt <= 0;
            if (timer_we) begin
                wr_off_q.push_back(toff[3:0]);
                wr_dat_q.push_back(timer_wdata);
                if (toff == 32'd8) mtimecmp[31:0] <= timer_wdata;
                if (toff == 32'd12) mtimecmp[63:32] <= timer_wdata;
            end else if (toff == 32'd0 && bump_arm && !bump_done) begin
                mtime     <= mtime + 64'd1;
                bump_done <= 1'b1;
            end
            if (!timer_we && toff == 32'd4) hi_reads <= hi_reads + 1;
        end
        if (prev_stall && (!timer_req || timer_addr != prev_addr || timer_wdata != prev_wdata ||
                           timer_we != prev_we)) stab_err <= stab_err + 1;
        prev_stall <= timer_req && stalling;
        prev_addr  <= timer_addr;
        prev_wdata <= timer_wdata;
        prev_we    <= timer_we;
    end

    int total = 0, bad = 0;

    // All stimulus tasks start and end on a falling edge.
    task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_req = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        #1;
        d = cfg_rdata;
        e = cfg_err;
        @(negedge clk);
        cfg_req = 1'b0;
    endtask

    task automatic load_mt(input logic [63:0] v);
        load_val = v; load_mtime = 1;
        @(negedge clk);
        load_mtime = 0;
    endtask

    task automatic settle;
        int quiet = 0;
        for (int n = 0; n < 4000 && quiet < 20; n++) begin
            @(negedge clk);
            if (timer_req) quiet = 0;
            else quiet++;
        end
        total++;
        if (quiet < 20) begin bad++; $display("FAIL settle: timer bus still busy, quiet=%0d want 20", quiet); end
    endtask

    task automatic clear_all;
        for (int c = 0; c < NumChan; c++) cfg_wr(32'(16 * c + 8), 32'd2);
        settle();
    endtask

    task automatic test_reset;
        logic [31:0] d; logic e; bit saw = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({timer_req, irq, cfg_rvalid, cfg_err} !== 4'b0 || timer_addr !== '0 || cfg_rdata !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%0b irq=%0b rvalid=%0b err=%0b addr=%0h want all 0",
                     timer_req, irq, cfg_rvalid, cfg_err, timer_addr);
        end
        rst_n = 1'b1;
        repeat (10) begin @(negedge clk); if (timer_req !== 1'b0 || irq !== 1'b0) saw = 1; end
        total++;
        if (saw) begin bad++; $display("FAIL reset_quiet: got activity after reset want none"); end
        cfg_rd(32'h100, d, e);
        total++;
        if (d !== 0 || e !== 0) begin bad++; $display("FAIL reset_pend: got %0h err %0b want 0 0", d, e); end
        cfg_rd(32'h8, d, e);
        total++;
        if (d !== 0 || e !== 0) begin bad++; $display("FAIL reset_ctrl0: got %0h err %0b want 0 0", d, e); end
    endtask

    task automatic test_cfg_map;
        logic [31:0] d, lo, hi; logic e;
        logic [31:0] bad_addr[3] = '{32'h0C, 32'h104, 32'h40};
        lo = $urandom; hi = $urandom;
        cfg_wr(32'h30, lo);
        cfg_wr(32'h34, hi);
        cfg_rd(32'h30, d, e);
        total++;
        if (d !== lo || e !== 0) begin bad++; $display("FAIL dl3_lo: got %0h want %0h", d, lo); end
        cfg_rd(32'h34, d, e);
        total++;
        if (d !== hi || e !== 0) begin bad++; $display("FAIL dl3_hi: got %0h want %0h", d, hi); end
        for (int i = 0; i < 3; i++) begin
            cfg_wr(bad_addr[i], 32'hFFFF_FFFF);
            cfg_rd(bad_addr[i], d, e);
            total++;
            if (d !== 0 || e !== 1'b1) begin
                bad++; $display("FAIL unmapped %0h: got %0h err %0b want 0 1", bad_addr[i], d, e);
            end
        end
        #1;
        total++;
        if (cfg_rvalid !== 0 || cfg_rdata !== 0 || cfg_err !== 0) begin
            bad++; $display("FAIL idle_cfg: got rvalid=%0b rdata=%0h err=%0b want 0", cfg_rvalid, cfg_rdata, cfg_err);
        end
        @(negedge clk);
        cfg_wr(32'h30, 0);
        cfg_wr(32'h34, 0);
    endtask

    task automatic test_two_chan;
        logic [31:0] d; logic e; int s; bit seen = 0; logic [63:0] mt = '0;
        s = wr_off_q.size();
        cfg_wr(32'h00, 1000); cfg_wr(32'h04, 0); cfg_wr(32'h10, 500); cfg_wr(32'h14, 0);
        cfg_wr(32'h08, 1); cfg_wr(32'h18, 1);
        settle();
        total++;
        if (wr_off_q.size() < s + 3 || wr_off_q[s] !== 4'd8 || wr_dat_q[s] !== 32'hFFFF_FFFF ||
            wr_off_q[s+1] !== 4'd12 || wr_dat_q[s+1] !== 0 || wr_off_q[s+2] !== 4'd8 || wr_dat_q[s+2] !== 500) begin
            bad++; $display("FAIL prog_seq: got %0d writes, first off %0h data %0h want (8,ffffffff)(c,0)(8,1f4)",
                            wr_off_q.size() - s, wr_off_q[s], wr_dat_q[s]);
        end
        total++;
        if (mtimecmp !== 64'd500) begin bad++; $display("FAIL cmp_500: got %0h want 1f4", mtimecmp); end
        tick_en = 1;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (irq) begin seen = 1; mt = mtime; end
        end
        tick_en = 0;
        total++;
        if (!seen || mt < 64'd500 || mt > 64'd520) begin
            bad++; $display("FAIL irq_at_500: got seen=%0b mtime=%0d want seen at 500..520", seen, mt);
        end
        settle();
        cfg_rd(32'h100, d, e);
        total++;
        if (d !== 32'h2 || irq !== 1'b1) begin bad++; $display("FAIL pend_ch1: got %0h irq %0b want 2 1", d, irq); end
        total++;
        if (mtimecmp !== 64'd1000) begin bad++; $display("FAIL cmp_1000: got %0h want 3e8", mtimecmp); end
        clear_all();
    endtask

    task automatic test_equal;
        logic [31:0] d; logic e;
        load_mt(0);
        cfg_wr(32'h20, 300); cfg_wr(32'h24, 0); cfg_wr(32'h30, 300); cfg_wr(32'h34, 0);
        cfg_wr(32'h28, 1); cfg_wr(32'h38, 1);
        settle();
        total++;
        if (mtimecmp !== 64'd300) begin bad++; $display("FAIL cmp_300: got %0h want 12c", mtimecmp); end
        load_mt(300);
        settle();
        cfg_rd(32'h100, d, e);
        total++;
        if (d !== 32'hC || irq !== 1'b1) begin bad++; $display("FAIL pend_equal: got %0h irq %0b want c 1", d, irq); end
        total++;
        if (mtimecmp !== '1) begin bad++; $display("FAIL cmp_max: got %0h want all ones", mtimecmp); end
        clear_all();
    endtask

    task automatic test_past;
        logic [31:0] d; logic e; int s;
        load_mt(100);
        s = hi_reads;
        cfg_wr(32'h00, 5); cfg_wr(32'h04, 0); cfg_wr(32'h08, 1);
        settle();
        cfg_rd(32'h08, d, e);
        total++;
        if (d !== 32'h2 || hi_reads <= s) begin
            bad++; $display("FAIL past_ctrl0: got %0h hi_reads+%0d want 2 with an mtime read", d, hi_reads - s);
        end
        total++;
        if (mtimecmp !== '1) begin bad++; $display("FAIL past_cmp: got %0h want all ones", mtimecmp); end
    endtask

    task automatic test_carry;
        logic [31:0] d; logic e; int s;
        clear_all();
        load_mt(64'h1_FFFF_FFFF);
        cfg_wr(32'h00, 0); cfg_wr(32'h04, 2); cfg_wr(32'h10, 1); cfg_wr(32'h14, 2);
        cfg_wr(32'h08, 1); cfg_wr(32'h18, 1);
        settle();
        total++;
        if (mtimecmp !== 64'h2_0000_0000) begin bad++; $display("FAIL carry_cmp0: got %0h want 200000000", mtimecmp); end
        s = hi_reads;
        bump_arm = 1; force_intr = 1;
        @(negedge clk);
        force_intr = 0;
        settle();
        total++;
        if (hi_reads - s !== 4) begin bad++; $display("FAIL carry_retry: got %0d hi reads want 4", hi_reads - s); end
        cfg_rd(32'h100, d, e);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL carry_pend: got %0h want 1", d); end
        total++;
        if (mtimecmp !== 64'h2_0000_0001) begin bad++; $display("FAIL carry_cmp1: got %0h want 200000001", mtimecmp); end
    endtask

    task automatic test_stall_w1c;
        logic [31:0] d; logic e; int s, se, ss, nhi = 0;
        logic [31:0] hi_dat = '1;
        for (int c = 0; c < NumChan; c++) cfg_wr(32'(16 * c + 8), 0);
        settle();
        load_mt(0);
        stall_hi_n = 3;
        s = wr_off_q.size(); se = stab_err; ss = stall_seen;
        cfg_wr(32'h10, 2000); cfg_wr(32'h14, 0); cfg_wr(32'h18, 1);
        settle();
        stall_hi_n = 0;
        for (int i = s; i < wr_off_q.size(); i++) if (wr_off_q[i] == 4'd12) begin nhi++; hi_dat = wr_dat_q[i]; end
        total++;
        if (nhi != 1 || hi_dat !== 0 || stall_seen - ss != 3) begin
            bad++; $display("FAIL stall_hi: got %0d hi writes data %0h stalls %0d want 1 0 3", nhi, hi_dat, stall_seen - ss);
        end
        total++;
        if (stab_err != se) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", stab_err - se); end
        total++;
        if (mtimecmp !== 64'd2000) begin bad++; $display("FAIL stall_cmp: got %0h want 7d0", mtimecmp); end
        cfg_req = 1; cfg_we = 1; cfg_addr = 32'h08; cfg_wdata = 32'h2;
        #1;
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL w1c_before: got irq %0b want 1", irq); end
        @(negedge clk);
        cfg_req = 0; cfg_we = 0;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop: got irq %0b want 0", irq); end
        cfg_rd(32'h100, d, e);
        total++;
        if (d !== 0) begin bad++; $display("FAIL w1c_pend: got %0h want 0", d); end
        clear_all();
    endtask

    task automatic test_random;
        logic [63:0] t, dl[NumChan], exp_cmp;
        bit          arm[NumChan];
        logic [31:0] d, exp_pend; logic e;
        int          off;
        for (int it = 0; it < 10; it++) begin
            clear_all();
            t = {32'($urandom_range(0, 3)), $urandom};
            load_mt(t);
            for (int c = 0; c < NumChan; c++) begin
                off = $urandom_range(0, 60);
                if ($urandom_range(0, 4) == 0) dl[c] = {$urandom, $urandom};
                else if ($urandom_range(0, 1) == 1) dl[c] = t - 64'(off);
                else dl[c] = t + 64'(off);
                arm[c] = 1'($urandom_range(0, 1));
                cfg_wr(32'(16 * c), dl[c][31:0]);
                cfg_wr(32'(16 * c + 4), dl[c][63:32]);
            end
            for (int c = 0; c < NumChan; c++) if (arm[c]) cfg_wr(32'(16 * c + 8), 1);
            settle();
            // Armed deadlines at or before now expire; the rest leave the earliest in mtimecmp.
            exp_pend = 0; exp_cmp = '1;
            for (int c = 0; c < NumChan; c++) begin
                if (arm[c] && dl[c] <= t) exp_pend[c] = 1'b1;
                else if (arm[c] && dl[c] < exp_cmp) exp_cmp = dl[c];
            end
            cfg_rd(32'h100, d, e);
            total++;
            if (d !== exp_pend || irq !== (exp_pend != 0)) begin
                bad++; $display("FAIL rnd_pend it%0d: got %0h irq %0b want %0h", it, d, irq, exp_pend);
            end
            total++;
            if (mtimecmp !== exp_cmp) begin bad++; $display("FAIL rnd_cmp it%0d: got %0h want %0h", it, mtimecmp, exp_cmp); end
            for (int c = 0; c < NumChan; c++) begin
                cfg_rd(32'(16 * c + 8), d, e);
                total++;
                if (d !== {30'b0, exp_pend[c], arm[c] && !exp_pend[c]}) begin
                    bad++; $display("FAIL rnd_ctrl it%0d ch%0d: got %0h want %0h", it, c, d,
                                    {30'b0, exp_pend[c], arm[c] && !exp_pend[c]});
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic e; bit busy = 0;
        clear_all();
        load_mt(0);
        cfg_wr(32'h00, 50); cfg_wr(32'h08, 1);
        for (int n = 0; n < 50 && !busy; n++) begin
            #1; if (timer_req) busy = 1;
            else @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (!busy || timer_req !== 1'b0 || irq !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got busy=%0b req=%0b irq=%0b want 1 0 0", busy, timer_req, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cfg_rd(32'h08, d, e);
        total++;
        if (d !== 0) begin bad++; $display("FAIL reset_mid_ctrl0: got %0h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_cfg_map();
        test_two_chan();
        test_equal();
        test_past();
        test_carry();
        test_stall_w1c();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Multiplexes NumChan independent 64-bit software deadlines onto the single mtime/mtimecmp timer.
- Acts as a bus host to the timer slave: reads mtime, finds the earliest armed deadline and programs mtimecmp with it. On timer interrupt, marks expired channels pending.
- The CPU sees a small register file (cfg port) plus one aggregated interrupt.

Parameters:
- NumChan, 4, number of deadline channels (2..8)
- DataWidth, 32, bus data width (must be 32)
- AddressWidth, 32, bus address width
- TimerBase, 32'h0003_0000, byte base address of timer; offsets MTIME_LO=0, MTIME_HI=4, MTIMECMP_LO=8, MTIMECMP_HI=12

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_req_i  in  1  CPU register access strobe
- cfg_we_i  in  1  write enable
- cfg_addr_i  in  AddressWidth  byte address; bits [9:0] decoded
- cfg_wdata_i  in  32  write data (full word only, no byte enables)
- cfg_rvalid_o  out  1  response valid, same cycle as cfg_req_i
- cfg_rdata_o  out  32  read data
- cfg_err_o  out  1  unmapped address
- timer_req_o  out  1  request to timer
- timer_addr_o  out  AddressWidth  TimerBase + offset
- timer_we_o  out  1  write enable
- timer_be_o  out  4  always 4'hF
- timer_wdata_o  out  32  write data
- timer_rvalid_i  in  1  timer response; same cycle as request
- timer_rdata_i  in  32  timer read data
- timer_intr_i  in  1  timer interrupt (mtime >= mtimecmp)
- irq_o  out  1  OR of all pending bits

Behaviour:
- Reset: all deadlines 0; armed, pending and dirty cleared; FSM in IDLE. All outputs 0, including timer_req_o, cfg_rvalid_o and irq_o.
- Cfg map, channel c at 16*c:
  - +0 DL_LO (rw)
  - +4 DL_HI (rw)
  - +8 CTRL: bit0 armed (rw); bit1 pending (read, write-1-clears)
  - 0x100 PEND: read-only pending vector
  - Any other address gives rdata 0 and cfg_err_o=1; writes to it are ignored.
- cfg_rvalid_o = cfg_req_i combinationally. rdata and err are 0 when there is no request.
- The dirty flag is set by:
  - any CTRL write that changes armed;
  - any DL_LO/DL_HI write to an armed channel.
- Timer host rule:
  - Each access is a single cycle with timer_req_o=1.
  - The access completes when timer_rvalid_i=1 in that cycle. Otherwise the request is held with the same address and data.
- FSM:
  - IDLE: if timer_intr_i and any channel armed, go to RD_HI. Else if dirty, go to SCAN. Interrupt takes priority.
  - RD_HI, RD_LO, RD_HI2: read mtime high, low, then high again. If the two high reads differ, restart at RD_HI (carry crossed). Else latch now = {hi, lo} and go to EXPIRE.
  - EXPIRE: one channel per cycle, index 0..NumChan-1. If armed and deadline <= now (unsigned 64-bit), set pending and clear armed. After the last channel, go to SCAN.
  - SCAN: clear dirty on entry. One channel per cycle; track the minimum deadline among armed channels, ties resolved to the lower index. If none is armed, target = 64'hFFFF_FFFF_FFFF_FFFF.
  - Programming: WR_LO_MAX writes MTIMECMP_LO=32'hFFFF_FFFF, then WR_HI writes target[63:32], then WR_LO writes target[31:0], then IDLE. This order prevents a transient early match.
- Deadlines already in the past simply re-raise timer_intr_i within 2 cycles and are handled by the normal expiry path.
- A spurious timer_intr_i (nothing expired) still reprograms mtimecmp. The timer's interrupt clears on the mtimecmp write.
- Same cycle as EXPIRE clearing armed: a cfg CTRL write to that channel wins, and dirty is set.
- A cfg deadline write during SCAN or programming sets dirty, so a rescan follows.
- Pending set by EXPIRE and a W1C in the same cycle: set wins.
- irq_o is registered: asserted the cycle after a pending bit is set.
- Reset mid-operation: the asynchronous reset returns to IDLE immediately. timer_req_o is dropped and the timer keeps whatever mtimecmp it had.

Test Plan:
- Reset, then read PEND and CTRL0 → 0, 0. irq_o=0 and timer_req_o=0 throughout.
- Program ch0=1000, ch1=500 and arm both → timer write sequence: (addr 8, FFFF_FFFF), (addr 12, 0), (addr 8, 500). At mtime≥500, PEND=2'b10 and irq_o=1. mtimecmp is then reprogrammed to 1000.
- ch2=ch3=300, both armed (equal deadlines) → SCAN picks ch2. Both expire in the same pass, PEND=4'b1100. Then mtimecmp = all-ones.
- Arm ch0 with deadline 5 while mtime=100 (in the past) → interrupt within 2 cycles after programming, and pending[0] set.
- mtime high read changes between RD_HI and RD_HI2 (stub the timer at lo=FFFF_FFFF then carry) → one retry, and correct now is used.
- Stall timer_rvalid_i low for 3 cycles during WR_HI → request held stable with no duplicated write. Then write 1 to CTRL0 bit1 → pending cleared and irq_o drops next cycle.
